dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the RISC-V core's load/store path. It accepts one load or store request at a time over a valid/ready handshake, inserts a configurable number of wait states, and applies RV32I byte/halfword/word sizing with sign or zero extension. It returns read data, or an error flag, over a second valid/ready handshake. The core's memory-stage stall logic sits on the request side of this block, replacing the single-cycle data memory.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle RV32I data-memory responder with configurable wait
// states and byte/halfword/word sizing behind request/response valid/ready handshakes.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [2:0]    f3_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept, in_err, do_access;
  logic          acc_we;
  logic [AW+1:0] acc_addr;
  logic [2:0]    acc_f3;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [3:0]    acc_be;
  logic [31:0]   wr_data, rd_word, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          f3_illegal, misaligned, out_of_range;

  assign accept = req_valid && req_ready;

  // Checked on the incoming fields so the accept edge can pick WAIT or RESP;
  // identical to checking the latched copy, which holds exactly these values.
  always_comb begin
    f3_illegal   = req_we ? (req_funct3 > 3'd2)
                          : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
    misaligned   = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                   (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    out_of_range = |req_addr[31:AW+2];
    in_err       = f3_illegal || misaligned || out_of_range;
  end

  always_comb begin
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr[AW+1:0];
      acc_f3    = req_funct3;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_f3    = f3_q;
      acc_wdata = wdata_q;
    end
  end

  assign do_access = (state == IDLE) ? (accept && !in_err && LATENCY == 0)
                                     : (state == WAIT && cnt == 4'd1);
  assign acc_idx   = acc_addr[AW+1:2];

  always_comb begin
    case (acc_f3[1:0])
      2'd0: begin
        acc_be  = 4'b0001 << acc_addr[1:0];
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        acc_be  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        acc_be  = 4'b1111;
        wr_data = acc_wdata;
      end
    endcase
  end

  assign rd_word = mem[acc_idx];
  assign ld_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
  assign ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (acc_f3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (in_err || LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[AW+1:0];
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        cnt     <= (in_err || LATENCY == 0) ? '0 : 4'(LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (accept && in_err) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if (do_access) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= acc_we ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_access && acc_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against a byte-addressed reference memory model.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [DEPTH*4];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32I sizing rules on a byte array; stores commit only when legal.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int unsigned size;
    bit illegal;
    illegal = 1'b0;
    size    = 4;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    illegal = 1'b1;
      endcase
    end
    err = illegal || (addr % size != 0) || (addr >= DEPTH*4);
    rd  = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) mdl[addr + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < int'(size); i++) rd[8*i +: 8] = mdl[addr + i];
        if (f3 < 3'd4 && size < 4 && rd[8*size-1])
          for (int j = 8*size; j < 32; j++) rd[j] = 1'b1;
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd,
                     output logic [31:0] rd_o, output logic err_o);
    logic        e_err;
    logic [31:0] e_rd;
    int          n;
    model(we, addr, f3, wd, e_err, e_rd);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_wait"}, n, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, e_err ? 0 : LAT);
    check({tag, "_rdata"}, rsp_rdata, e_rd);
    check({tag, "_err"}, rsp_err, e_err);
    rd_o  = rsp_rdata;
    err_o = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_valid_after"}, rsp_valid, 0);
  endtask

  task automatic start_and_reset(input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_funct3 = 3'd2;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_wait_req_ready", req_ready, 1);
    check("rst_wait_rsp_valid", rsp_valid, 0);
    check("rst_wait_rsp_rdata", rsp_rdata, 0);
    check("rst_wait_rsp_err", rsp_err, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int unsigned r;
    logic [31:0] a;

    #2;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_rsp", rsp_valid, 0);
    end

    txn("sw10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, er);
    txn("lw10", 1'b0, 32'h10, 3'd2, '0, rd, er);
    check("lw10_const", rd, 32'hDEADBEEF);
    txn("lb13", 1'b0, 32'h13, 3'd0, '0, rd, er);
    check("lb13_const", rd, 32'hFFFFFFDE);
    txn("lbu13", 1'b0, 32'h13, 3'd4, '0, rd, er);
    check("lbu13_const", rd, 32'h000000DE);
    txn("lh12", 1'b0, 32'h12, 3'd1, '0, rd, er);
    check("lh12_const", rd, 32'hFFFFDEAD);
    txn("lhu10", 1'b0, 32'h10, 3'd5, '0, rd, er);
    check("lhu10_const", rd, 32'h0000BEEF);
    txn("sb11", 1'b1, 32'h11, 3'd0, 32'h55, rd, er);
    txn("lw10b", 1'b0, 32'h10, 3'd2, '0, rd, er);
    check("lw10b_const", rd, 32'hDEAD55EF);

    txn("e_lw12", 1'b0, 32'h12, 3'd2, '0, rd, er);
    check("e_lw12_flag", er, 1);
    txn("e_sh11", 1'b1, 32'h11, 3'd1, 32'hFFFF, rd, er);
    check("e_sh11_flag", er, 1);
    txn("e_range", 1'b0, DEPTH*4, 3'd2, '0, rd, er);
    check("e_range_flag", er, 1);
    txn("e_f3", 1'b0, 32'h10, 3'd3, '0, rd, er);
    check("e_f3_flag", er, 1);
    txn("lw10c", 1'b0, 32'h10, 3'd2, '0, rd, er);
    check("lw10c_const", rd, 32'hDEAD55EF);

    // Backpressure: a store presented while the response is held must be ignored.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_we    = 1'b1;
    req_wdata = 32'h0;
    r = 0;
    while (!rsp_valid && r < 40) begin
      @(negedge clk);
      r++;
    end
    check("hold_latency", r, LAT);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, 32'hDEAD55EF);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_release_ready", req_ready, 1);
    txn("lw10d", 1'b0, 32'h10, 3'd2, '0, rd, er);
    check("lw10d_const", rd, 32'hDEAD55EF);

    start_and_reset(32'h12345678);
    txn("sw20_zero", 1'b1, 32'h20, 3'd2, 32'h0, rd, er);
    start_and_reset(32'hFFFFFFFF);
    txn("lw20", 1'b0, 32'h20, 3'd2, '0, rd, er);
    check("lw20_const", rd, 32'h0);

    for (int w = 0; w < int'(DEPTH); w++)
      txn("fill", 1'b1, 32'(w * 4), 3'd2, $urandom, rd, er);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      a = (r == 0) ? $urandom : $urandom_range(0, DEPTH*4 - 1);
      txn("rnd", 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
